// File: rtl/hc05_byte_ctrl_pkg.sv
// Shared definitions for the HC-05 byte controller: TX FSM state encoding and default sizing.
package hc05_byte_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } tx_state_e;

    localparam int DEF_TX_DEPTH   = 16;
    localparam int DEF_RX_DEPTH   = 16;
    localparam int DEF_TX_TIMEOUT = 600000;

endpackage

// File: rtl/hc05_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with exact occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module hc05_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/hc05_byte_ctrl.sv
// Host-side HC-05 byte controller: TX FIFO paced one byte per strobe/tx_end handshake,
// RX FIFO capturing link bytes, sticky timeout and overflow flags.
module hc05_byte_ctrl
    import hc05_byte_ctrl_pkg::*;
#(
    parameter int TX_DEPTH   = DEF_TX_DEPTH,
    parameter int RX_DEPTH   = DEF_RX_DEPTH,
    parameter int TX_TIMEOUT = DEF_TX_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    output logic                        tx_full,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    input  logic                        tx_pause,
    output logic                        tx_busy,
    output logic                        tx_err,
    input  logic                        rd_en,
    output logic [7:0]                  rd_data,
    output logic                        rx_empty,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic                        rx_overflow,
    input  logic                        err_clr,
    output logic [7:0]                  link_data_o,
    output logic                        link_en_o,
    input  logic                        link_tx_end,
    input  logic [7:0]                  link_data_i,
    input  logic                        link_en_i
);
    localparam int CW = $clog2(TX_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TX_TIMEOUT - 1);

    tx_state_e     state;
    logic [CW-1:0] to_cnt;
    logic [7:0]    tx_rdata;
    logic          tx_empty, tx_pop, to_hit;
    logic          rx_full, rx_drop;

    hc05_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (wr_en),
        .wdata (wr_data),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    hc05_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (link_en_i),
        .wdata (link_data_i),
        .pop   (rd_en),
        .rdata (rd_data),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    assign tx_pop  = (state == ST_IDLE) && !tx_empty && !tx_pause;
    assign to_hit  = (state == ST_WAIT) && !link_tx_end && (to_cnt == TO_LAST);
    // A full FIFO still takes the byte when the host pops in the same cycle.
    assign rx_drop = link_en_i && rx_full && !rd_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            link_data_o <= 8'h00;
            link_en_o   <= 1'b0;
            tx_busy     <= 1'b0;
            to_cnt      <= '0;
        end else begin
            link_en_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_pop) begin
                        link_data_o <= tx_rdata;
                        link_en_o   <= 1'b1;
                        tx_busy     <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    to_cnt <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (link_tx_end || to_hit) begin
                        tx_busy <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_busy <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_err      <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            tx_err      <= err_clr ? 1'b0 : (tx_err | to_hit);
            rx_overflow <= err_clr ? 1'b0 : (rx_overflow | rx_drop);
        end
    end

endmodule
